// File: rtl/gamma_table_loader_pkg.sv
// Shared sizing and state encoding for the gamma table loader.
`default_nettype none

package gamma_table_loader_pkg;

   localparam int GTL_ENTRIES = 256;
   localparam int GTL_ADDR_W  = 8;
   localparam int GTL_DATA_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_CHECK   = 2'd2,
      ST_PENDING = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/gamma_table_loader_rise_edge_detect.sv
// rise_edge_detect: one-cycle strobe on a 0->1 transition of a synchronous level.
`default_nettype none

module rise_edge_detect (
   input  logic clock,
   input  logic reset_n,
   input  logic in_i,
   output logic pulse_o
);

   logic in_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in_i;
      end
   end

   assign pulse_o = in_i & ~in_q;

endmodule

`default_nettype wire

// File: rtl/gamma_table_loader.sv
// gamma_table_loader: streams a gamma curve into a shadow buffer and commits it on vsync.
// Optional trailing checksum byte enabled by GAMMA_LOADER_CHECKSUM_EN.
`default_nettype none

module gamma_table_loader
   import gamma_table_loader_pkg::*;
#(
   parameter int ENTRIES = GTL_ENTRIES,
   parameter int ADDR_W  = GTL_ADDR_W,
   parameter int DATA_W  = GTL_DATA_W
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              load_start,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic              vsync,
   output logic [DATA_W-1:0] mapper [0:ENTRIES-1],
   output logic              busy,
   output logic              commit_done,
   output logic              error
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              error_q, error_d;
   logic              commit_q, commit_d;
   logic [DATA_W-1:0] shadow_q [0:ENTRIES-1];
   logic [DATA_W-1:0] mapper_q [0:ENTRIES-1];
   logic              vsync_rise;
   logic              xfer;
   logic              last_entry;
`ifdef GAMMA_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
`endif

   rise_edge_detect u_vsync_edge (
      .clock   (clock),
      .reset_n (reset_n),
      .in_i    (vsync),
      .pulse_o (vsync_rise)
   );

   // load_start takes priority, so a byte offered alongside it is refused.
   assign data_ready = ((state_q == ST_LOAD) || (state_q == ST_CHECK)) && !load_start;
   assign xfer       = data_valid && data_ready;
   assign last_entry = (idx_q == ADDR_W'(ENTRIES - 1));

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      error_d  = error_q;
      commit_d = 1'b0;
`ifdef GAMMA_LOADER_CHECKSUM_EN
      sum_d    = sum_q;
`endif
      // An abort would flag error, but the restart clears it on the same edge.
      if (load_start) begin
         state_d = ST_LOAD;
         idx_d   = '0;
         error_d = 1'b0;
`ifdef GAMMA_LOADER_CHECKSUM_EN
         sum_d   = '0;
`endif
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (xfer) begin
                  idx_d = idx_q + ADDR_W'(1);
`ifdef GAMMA_LOADER_CHECKSUM_EN
                  sum_d = sum_q + data_in;
                  if (last_entry) state_d = ST_CHECK;
`else
                  if (last_entry) state_d = ST_PENDING;
`endif
               end
            end
`ifdef GAMMA_LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (xfer) begin
                  if (data_in == sum_q) begin
                     state_d = ST_PENDING;
                  end else begin
                     error_d = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
            end
`endif
            ST_PENDING: begin
               if (vsync_rise) begin
                  commit_d = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         error_q  <= 1'b0;
         commit_q <= 1'b0;
`ifdef GAMMA_LOADER_CHECKSUM_EN
         sum_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         error_q  <= error_d;
         commit_q <= commit_d;
`ifdef GAMMA_LOADER_CHECKSUM_EN
         sum_q    <= sum_d;
`endif
      end
   end

   // Identity tables keep the custom gamma mode pass-through until a curve is committed.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            shadow_q[i] <= DATA_W'(i);
            mapper_q[i] <= DATA_W'(i);
         end
      end else begin
         if (xfer && (state_q == ST_LOAD)) begin
            shadow_q[idx_q] <= data_in;
         end
         if (commit_d) begin
            mapper_q <= shadow_q;
         end
      end
   end

   assign mapper      = mapper_q;
   assign busy        = (state_q != ST_IDLE);
   assign commit_done = commit_q;
   assign error       = error_q;

endmodule

`default_nettype wire
